// File: rtl/store_mem_responder.sv
// Memory-side responder for the store reservation station: queues accepted stores in order,
// retires each one through a fixed-latency write FSM, and serves a registered load read port.
module store_mem_responder #(
    parameter int DEPTH         = 4,
    parameter int ADDR_BITS     = 8,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     requestEnable,
    input  logic [2:0]               requestRegister,
    input  logic [15:0]              requestAddress,
    input  logic [15:0]              R1,
    input  logic [15:0]              R2,
    input  logic [15:0]              R3,
    input  logic [15:0]              R4,
    input  logic [15:0]              R5,
    input  logic [15:0]              R6,
    input  logic [15:0]              R7,
    output logic                     requestReady,
    output logic                     storeDone,
    output logic [15:0]              storeDoneAddr,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   queueCount,
    output logic                     busy,
    input  logic [15:0]              readAddr,
    output logic [15:0]              readData
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LAT_W     = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam int MEM_WORDS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [15:0]         addr_q_r [DEPTH];
    logic [15:0]         data_q_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [LAT_W-1:0]    cnt_r;
    logic [15:0]         work_addr_r;
    logic [15:0]         work_data_r;
    logic                store_done_r;
    logic [15:0]         done_addr_r;
    logic                overflow_r;
    logic [15:0]         read_data_r;
    logic [15:0]         mem_r [MEM_WORDS];

    logic                request_ready_s;
    logic                push_s;
    logic                pop_s;
    logic                write_s;
    logic [15:0]         store_data_s;
    logic                unused_read_bits_s;

    assign request_ready_s    = (count_r != CNT_W'(DEPTH));
    assign push_s             = requestEnable && request_ready_s;
    assign unused_read_bits_s = &{1'b0, readAddr};

    assign requestReady  = request_ready_s;
    assign storeDone     = store_done_r;
    assign storeDoneAddr = done_addr_r;
    assign overflow      = overflow_r;
    assign queueCount    = count_r;
    assign busy          = (state_r != ST_IDLE) || (count_r != CNT_W'(0));
    assign readData      = read_data_r;

    // Register-file snapshot for the store being accepted; R0 is hardwired zero.
    always_comb begin
        store_data_s = 16'h0000;
        case (requestRegister)
            3'd1:    store_data_s = R1;
            3'd2:    store_data_s = R2;
            3'd3:    store_data_s = R3;
            3'd4:    store_data_s = R4;
            3'd5:    store_data_s = R5;
            3'd6:    store_data_s = R6;
            3'd7:    store_data_s = R7;
            default: store_data_s = 16'h0000;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (cnt_r == LAT_W'(0)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM control outputs; a write coinciding with reset is abandoned.
    always_comb begin
        pop_s   = 1'b0;
        write_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if ((cnt_r == LAT_W'(0)) && !reset) begin
                    write_s = 1'b1;
                end else begin
                    write_s = 1'b0;
                end
            end
            ST_DONE: begin
                pop_s   = 1'b0;
                write_s = 1'b0;
            end
            default: begin
                pop_s   = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    // In-order store queue; a full queue rejects even if the head pops this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                addr_q_r[wr_ptr_r] <= requestAddress;
                data_q_r[wr_ptr_r] <= store_data_s;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Working registers and write-latency counter for the store in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r       <= LAT_W'(0);
            work_addr_r <= 16'h0000;
            work_data_r <= 16'h0000;
        end else if (pop_s) begin
            cnt_r       <= LAT_W'(WRITE_LATENCY - 1);
            work_addr_r <= addr_q_r[rd_ptr_r];
            work_data_r <= data_q_r[rd_ptr_r];
        end else if ((state_r == ST_WRITE) && (cnt_r != LAT_W'(0))) begin
            cnt_r <= cnt_r - LAT_W'(1);
        end
    end

    // Completion pulse, reported address and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            store_done_r <= 1'b0;
            done_addr_r  <= 16'h0000;
            overflow_r   <= 1'b0;
        end else begin
            store_done_r <= write_s;
            if (write_s) begin
                done_addr_r <= work_addr_r;
            end
            if (requestEnable && !request_ready_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Data memory write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (write_s) begin
            mem_r[work_addr_r[ADDR_BITS-1:0]] <= work_data_r;
        end
    end

    // Registered load read, old data on a same-edge write to the same index.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_r <= 16'h0000;
        end else begin
            read_data_r <= mem_r[readAddr[ADDR_BITS-1:0]];
        end
    end

endmodule

// File: tb/tb_store_mem_responder.sv
// Randomized and directed bench for store_mem_responder against a schedule-based model
// that predicts each store's pop edge and completion edge arithmetically.
module tb_store_mem_responder;

    localparam int DEPTH = 4;
    localparam int WL    = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        requestEnable;
    logic [2:0]  requestRegister;
    logic [15:0] requestAddress;
    logic [15:0] rf [1:7];
    logic        requestReady;
    logic        storeDone;
    logic [15:0] storeDoneAddr;
    logic        overflow;
    logic [2:0]  queueCount;
    logic        busy;
    logic [15:0] readAddr;
    logic [15:0] readData;

    store_mem_responder #(.DEPTH(DEPTH), .ADDR_BITS(8), .WRITE_LATENCY(WL)) dut (
        .clock(clock), .reset(reset),
        .requestEnable(requestEnable), .requestRegister(requestRegister),
        .requestAddress(requestAddress),
        .R1(rf[1]), .R2(rf[2]), .R3(rf[3]), .R4(rf[4]), .R5(rf[5]), .R6(rf[6]), .R7(rf[7]),
        .requestReady(requestReady), .storeDone(storeDone), .storeDoneAddr(storeDoneAddr),
        .overflow(overflow), .queueCount(queueCount), .busy(busy),
        .readAddr(readAddr), .readData(readData)
    );

    always #5 clock = ~clock;

    // Model: every accepted store is tagged with the edge it leaves the queue.
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          start;
    } rec_t;

    rec_t        rq[$];
    logic [15:0] mem_m [0:255];
    bit          known_m [0:255];
    int          e_m = 0;
    int          last_start = 0;
    bit          have_last = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_done_addr = 16'h0000;
    logic [15:0] m_rd = 16'h0000;
    bit          m_rd_known = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          done_seen = 0;
    logic [15:0] watch_addr = 16'hFFFF;
    bit          watch_hit = 1'b0;

    function automatic int pending(int from);
        int c = 0;
        foreach (rq[i]) if (rq[i].start >= from) c++;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int st;
        e_m++;
        if (reset) begin
            rq.delete();
            m_ovf = 1'b0; m_done = 1'b0; m_done_addr = 16'h0000;
            m_rd = 16'h0000; m_rd_known = 1'b1; have_last = 1'b0;
        end else begin
            m_rd       = mem_m[readAddr[7:0]];
            m_rd_known = known_m[readAddr[7:0]];
            m_done     = 1'b0;
            if (rq.size() > 0 && rq[0].start + WL == e_m) begin
                mem_m[rq[0].addr[7:0]]   = rq[0].data;
                known_m[rq[0].addr[7:0]] = 1'b1;
                m_done      = 1'b1;
                m_done_addr = rq[0].addr;
                void'(rq.pop_front());
            end
            if (requestEnable) begin
                if (pending(e_m) < DEPTH) begin
                    rec_t r;
                    st = e_m + 1;
                    if (have_last && (last_start + WL + 2 > st)) st = last_start + WL + 2;
                    r.addr  = requestAddress;
                    r.data  = (requestRegister == 3'd0) ? 16'h0000 : rf[requestRegister];
                    r.start = st;
                    rq.push_back(r);
                    last_start = st;
                    have_last  = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        int cnt;
        cnt = pending(e_m + 1);
        chk("requestReady", requestReady, (cnt < DEPTH));
        chk("queueCount", queueCount, cnt);
        chk("busy", busy, (rq.size() != 0) || m_done);
        chk("storeDone", storeDone, m_done);
        chk("storeDoneAddr", storeDoneAddr, m_done_addr);
        chk("overflow", overflow, m_ovf);
        if (m_rd_known) chk("readData", readData, m_rd);
        if (storeDone === 1'b1) begin
            done_seen++;
            if (storeDoneAddr === watch_addr) watch_hit = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic issue(input logic [2:0] r, input logic [15:0] a);
        requestEnable   = 1'b1;
        requestRegister = r;
        requestAddress  = a;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            step();
            k++;
        end while (busy !== 1'b0 && k < 60);
        if (busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got busy=%0b expected 0 within 60 cycles", busy);
        end
    endtask

    initial begin
        foreach (known_m[i]) known_m[i] = 1'b0;
        foreach (rf[i]) rf[i] = 16'h0000;
        reset = 1'b1; requestEnable = 1'b0; requestRegister = 3'd0;
        requestAddress = 16'h0000; readAddr = 16'h0000;
        step(); step();
        reset = 1'b0;
        chk("rst_count", queueCount, 0);
        chk("rst_done", storeDone, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_read", readData, 16'h0000);
        chk("rst_busy", busy, 0);

        // Single store: completion visible after the third edge past acceptance.
        rf[3] = 16'hBEEF;
        issue(3'd3, 16'h0010);
        step();
        requestEnable = 1'b0;
        step(); step();
        chk("single_early", storeDone, 0);
        step();
        chk("single_done", storeDone, 1);
        chk("single_addr", storeDoneAddr, 16'h0010);
        readAddr = 16'h0010;
        step();
        chk("single_read", readData, 16'hBEEF);

        // Snapshot of the register value at the accept edge.
        rf[2] = 16'h1111;
        issue(3'd2, 16'h0020);
        step();
        requestEnable = 1'b0;
        rf[2] = 16'h2222;
        wait_idle();
        readAddr = 16'h0020;
        step();
        chk("snapshot_read", readData, 16'h1111);

        // R0 store writes zero.
        issue(3'd0, 16'h0005);
        step();
        requestEnable = 1'b0;
        wait_idle();
        readAddr = 16'h0005;
        step();
        chk("r0_read", readData, 16'h0000);

        // Fill to full, then one dropped request.
        begin
            int k = 0;
            done_seen = 0;
            while (requestReady && k < 10) begin
                rf[1] = 16'(k + 1);
                issue(3'd1, 16'h0030 + 16'(k));
                step();
                k++;
            end
            chk("fill_pushes", k, 5);
            rf[1] = 16'h0063;
            watch_addr = 16'h0030 + 16'(k);
            issue(3'd1, watch_addr);
            step();
            requestEnable = 1'b0;
            chk("ovf_set", overflow, 1);
            chk("ovf_count", queueCount, 3);
            wait_idle();
            chk("fill_completions", done_seen, 5);
            chk("dropped_absent", watch_hit, 0);
            readAddr = 16'h0034;
            step();
            chk("fill_last_read", readData, 16'h0005);
        end

        // Read-before-write on the index being written.
        readAddr = 16'h0010;
        rf[4] = 16'hCAFE;
        issue(3'd4, 16'h0010);
        step();
        requestEnable = 1'b0;
        step(); step(); step();
        chk("rbw_done", storeDone, 1);
        chk("rbw_old", readData, 16'hBEEF);
        step();
        chk("rbw_new", readData, 16'hCAFE);

        // Reset while a store is in WRITE with two more queued.
        rf[5] = 16'h4444;
        issue(3'd5, 16'h0040);
        step();
        requestEnable = 1'b0;
        wait_idle();
        rf[5] = 16'h9999;
        issue(3'd5, 16'h0040); step();
        issue(3'd5, 16'h0041); step();
        issue(3'd5, 16'h0042); step();
        requestEnable = 1'b0;
        chk("mid_count", queueCount, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_count", queueCount, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", storeDone, 0);
        chk("rst_mid_ovf", overflow, 0);
        readAddr = 16'h0040;
        step();
        chk("rst_mid_keep", readData, 16'h4444);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            requestEnable   = ($urandom_range(0, 2) != 0);
            requestRegister = 3'($urandom_range(0, 7));
            requestAddress  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
            rf[$urandom_range(1, 7)] = 16'($urandom());
            readAddr        = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
            step();
        end
        reset = 1'b0;
        requestEnable = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
